// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM macro.
// The lock_0/lock_1 inputs exist only when ARB_LOCK_EN is defined.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req_0;
  logic              req_1;
  logic              we_0;
  logic              we_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_0;
  logic [DATA_W-1:0] wdata_1;
`ifdef ARB_LOCK_EN
  logic              lock_0;
  logic              lock_1;
`endif
  logic              gnt_0;
  logic              gnt_1;
  logic              ack_0;
  logic              ack_1;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
`ifdef ARB_LOCK_EN
    input  lock_0, lock_1,
`endif
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, ram_rdata,
    output gnt_0, gnt_1, ack_0, ack_1, rdata_0, rdata_1, busy,
    output ram_addr, ram_we, ram_oe, ram_wdata
  );

  // Requesters plus RAM side.
  modport master (
`ifdef ARB_LOCK_EN
    output lock_0, lock_1,
`endif
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, ram_rdata,
    input  gnt_0, gnt_1, ack_0, ack_1, rdata_0, rdata_1, busy,
    input  ram_addr, ram_we, ram_oe, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between two requesters.
// Define ARB_LOCK_EN to add lock_0/lock_1 inputs that let a winner keep up to LOCK_MAX grants.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic         clk,
  input logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;    // last-served requester, doubles as current winner
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              req_any;
  logic              win;

`ifdef ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_last, req_last, lock_hold, lock_win;

  assign lock_last = last_q ? bus.lock_1 : bus.lock_0;
  assign req_last  = last_q ? bus.req_1  : bus.req_0;
  assign lock_hold = lock_last && req_last && (32'(cnt_q) < LOCK_MAX);
  assign lock_win  = win ? bus.lock_1 : bus.lock_0;
`endif

  assign req_any = bus.req_0 | bus.req_1;

  always_comb begin
    if (bus.req_0 && bus.req_1) begin
`ifdef ARB_LOCK_EN
      win = lock_hold ? last_q : ~last_q;
`else
      win = ~last_q;
`endif
    end else begin
      win = bus.req_1;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
`ifdef ARB_LOCK_EN
    cnt_d    = cnt_q;
    if (state_q == StIdle && !lock_last) begin
      cnt_d = '0;
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StAcc;
          last_d  = win;
          we_d    = win ? bus.we_1    : bus.we_0;
          addr_d  = win ? bus.addr_1  : bus.addr_0;
          wdata_d = win ? bus.wdata_1 : bus.wdata_0;
`ifdef ARB_LOCK_EN
          if (!lock_win) begin
            cnt_d = '0;
          end else if (win != last_q) begin
            cnt_d = CntW'(1);
          end else if (32'(cnt_q) < LOCK_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StAcc: begin
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        ack0_d  = ~last_q;
        ack1_d  = last_q;
        // RAM data for the ACC-cycle address is valid throughout RESP.
        if (!we_q) begin
          if (last_q) begin
            rdata1_d = bus.ram_rdata;
          end else begin
            rdata0_d = bus.ram_rdata;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifdef ARB_LOCK_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
`ifdef ARB_LOCK_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Controls decode straight from state so reset removes them without waiting for a clock.
  assign bus.gnt_0     = (state_q == StAcc) && !last_q;
  assign bus.gnt_1     = (state_q == StAcc) && last_q;
  assign bus.ram_we    = (state_q == StAcc) && we_q;
  assign bus.ram_oe    = ((state_q == StAcc) || (state_q == StResp)) && !we_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ack_0     = ack0_q;
  assign bus.ack_1     = ack1_q;
  assign bus.rdata_0   = rdata0_q;
  assign bus.rdata_1   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level round-robin model and a shadow memory.
module tb_ram_arbiter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] ram_q;
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  ram_arbiter_if bus ();

  ram_arbiter u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_oe) ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus.we_0 = 1'b0; bus.we_1 = 1'b0;
    bus.addr_0 = 8'h00; bus.addr_1 = 8'h00; bus.wdata_0 = 8'h00; bus.wdata_1 = 8'h00;
`ifdef ARB_LOCK_EN
    bus.lock_0 = 1'b0; bus.lock_1 = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [6:0] ctrl;
    ctrl = {bus.busy, bus.gnt_1, bus.gnt_0, bus.ack_1, bus.ack_0, bus.ram_we, bus.ram_oe};
    n_chk++;
    if (ctrl !== 7'b0) $display("FAIL reset_ctrl: got %b expected %b", ctrl, 7'b0);
    else n_pass++;
    n_chk++;
    if ({bus.rdata_1, bus.rdata_0} !== 16'h0)
      $display("FAIL reset_rdata: got %h expected 0000", {bus.rdata_1, bus.rdata_0});
    else n_pass++;
    n_chk++;
    if ({bus.ram_addr, bus.ram_wdata} !== 16'h0)
      $display("FAIL reset_ram_bus: got %h expected 0000", {bus.ram_addr, bus.ram_wdata});
    else n_pass++;
  endtask

  task automatic test_read();
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 8'h10;
    tick();
    bus.req_0 = 1'b0; bus.addr_0 = 8'h99;
    n_chk++;
    if ({bus.gnt_1, bus.gnt_0, bus.ram_oe, bus.ram_we} !== 4'b0110)
      $display("FAIL read_acc_ctrl: got %b expected 0110",
               {bus.gnt_1, bus.gnt_0, bus.ram_oe, bus.ram_we});
    else n_pass++;
    n_chk++;
    if (bus.ram_addr !== 8'h10) $display("FAIL read_addr: got %h expected 10", bus.ram_addr);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.gnt_0, bus.ram_oe, bus.ack_0} !== 3'b010)
      $display("FAIL read_resp: got %b expected 010", {bus.gnt_0, bus.ram_oe, bus.ack_0});
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.ack_1, bus.ack_0, bus.gnt_1} !== 3'b010)
      $display("FAIL read_ack: got %b expected 010", {bus.ack_1, bus.ack_0, bus.gnt_1});
    else n_pass++;
    n_chk++;
    if (bus.rdata_0 !== 8'h5A) $display("FAIL read_data: got %h expected 5a", bus.rdata_0);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.ack_0, bus.busy} !== 2'b00)
      $display("FAIL read_done: got %b expected 00", {bus.ack_0, bus.busy});
    else n_pass++;
  endtask

  task automatic test_write_readback();
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 8'hFF; bus.wdata_1 = 8'hC3;
    tick();
    bus.req_1 = 1'b0; bus.wdata_1 = 8'h00;
    exp_mem[8'hFF] = 8'hC3;
    n_chk++;
    if ({bus.gnt_1, bus.ram_we, bus.ram_oe, bus.ram_addr, bus.ram_wdata} !== {3'b110, 16'hFFC3})
      $display("FAIL write_acc: got %h expected %h",
               {bus.gnt_1, bus.ram_we, bus.ram_oe, bus.ram_addr, bus.ram_wdata},
               {3'b110, 16'hFFC3});
    else n_pass++;
    tick();
    n_chk++;
    if (bus.ram_we !== 1'b0) $display("FAIL write_we_pulse: got %b expected 0", bus.ram_we);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.ack_1, bus.rdata_1} !== {1'b1, 8'h00})
      $display("FAIL write_ack: got %h expected %h", {bus.ack_1, bus.rdata_1}, {1'b1, 8'h00});
    else n_pass++;
    bus.req_1 = 1'b1; bus.we_1 = 1'b0;
    tick();
    bus.req_1 = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({bus.ack_1, bus.rdata_1} !== {1'b1, 8'hC3})
      $display("FAIL readback: got %h expected %h", {bus.ack_1, bus.rdata_1}, {1'b1, 8'hC3});
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    reset = 1'b0;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1; bus.we_0 = 1'b0; bus.we_1 = 1'b0;
    bus.addr_0 = 8'h01; bus.addr_1 = 8'h02;
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = 2'b00;
      if (c % 3 == 1) e = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if ({bus.gnt_1, bus.gnt_0} !== e)
        $display("FAIL rr_gnt c%0d: got %b expected %b", c, {bus.gnt_1, bus.gnt_0}, e);
      else n_pass++;
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_write();
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 8'h20; bus.wdata_0 = 8'h77;
    tick();
    bus.req_0 = 1'b0;
    n_chk++;
    if (bus.ram_we !== 1'b1) $display("FAIL midrst_we_before: got %b expected 1", bus.ram_we);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.ram_we, bus.busy, bus.gnt_0} !== 3'b000)
      $display("FAIL midrst_async: got %b expected 000", {bus.ram_we, bus.busy, bus.gnt_0});
    else n_pass++;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1; bus.we_0 = 1'b0; bus.we_1 = 1'b0;
    tick();
    n_chk++;
    if ({bus.ack_1, bus.ack_0} !== 2'b00)
      $display("FAIL midrst_no_ack: got %b expected 00", {bus.ack_1, bus.ack_0});
    else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++;
    if ({bus.gnt_1, bus.gnt_0} !== 2'b01)
      $display("FAIL midrst_first_gnt: got %b expected 01", {bus.gnt_1, bus.gnt_0});
    else n_pass++;
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_idle();
    logic [6:0] ctrl;
    for (int c = 0; c < 10; c++) begin
      tick();
      ctrl = {bus.busy, bus.gnt_1, bus.gnt_0, bus.ack_1, bus.ack_0, bus.ram_we, bus.ram_oe};
      n_chk++;
      if (ctrl !== 7'b0) $display("FAIL idle c%0d: got %b expected 0000000", c, ctrl);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic       dreq  [2];
    logic       dwe   [2];
    logic [7:0] daddr [2];
    logic [7:0] dwd   [2];
    logic [7:0] exp_rd[2];
    logic       last, win, ack_who, ack_rd, g_we;
    logic [7:0] ack_val, g_addr;
    logic [1:0] exp_gnt, exp_ack, exp_ctl;
    logic       exp_busy;
    int         free_at, last_g, ack_at;
    for (int i = 0; i < 2; i++) begin
      dreq[i] = 1'b0; dwe[i] = 1'b0; daddr[i] = 8'h00; dwd[i] = 8'h00; exp_rd[i] = 8'h00;
    end
    last = 1'b1; free_at = 1; last_g = -10; ack_at = -10;
    ack_who = 1'b0; ack_rd = 1'b0; ack_val = 8'h00; g_we = 1'b0; g_addr = 8'h00;
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 450; c++) begin
      tick();
      // Model: an access occupies three cycles; a new grant needs requests seen while free.
      exp_gnt = 2'b00;
      if (c >= free_at && (dreq[0] || dreq[1])) begin
        win = (dreq[0] && dreq[1]) ? ~last : dreq[1];
        last = win;
        exp_gnt[win] = 1'b1;
        free_at = c + 3; last_g = c; ack_at = c + 2;
        ack_who = win; ack_rd = ~dwe[win]; g_we = dwe[win]; g_addr = daddr[win];
        if (dwe[win]) exp_mem[daddr[win]] = dwd[win];
        else ack_val = exp_mem[daddr[win]];
      end
      exp_ack = 2'b00;
      if (c == ack_at) begin
        exp_ack[ack_who] = 1'b1;
        if (ack_rd) exp_rd[ack_who] = ack_val;
      end
      exp_busy = (c == last_g) || (c == last_g + 1);
      exp_ctl  = {(c == last_g) && g_we, exp_busy && !g_we};
      n_chk++;
      if ({bus.gnt_1, bus.gnt_0, bus.ack_1, bus.ack_0} !== {exp_gnt, exp_ack})
        $display("FAIL rnd_gnt_ack c%0d: got %b expected %b", c,
                 {bus.gnt_1, bus.gnt_0, bus.ack_1, bus.ack_0}, {exp_gnt, exp_ack});
      else n_pass++;
      n_chk++;
      if ({bus.rdata_1, bus.rdata_0} !== {exp_rd[1], exp_rd[0]})
        $display("FAIL rnd_rdata c%0d: got %h expected %h", c,
                 {bus.rdata_1, bus.rdata_0}, {exp_rd[1], exp_rd[0]});
      else n_pass++;
      n_chk++;
      if ({bus.busy, bus.ram_we, bus.ram_oe} !== {exp_busy, exp_ctl})
        $display("FAIL rnd_ctrl c%0d: got %b expected %b", c,
                 {bus.busy, bus.ram_we, bus.ram_oe}, {exp_busy, exp_ctl});
      else n_pass++;
      if (exp_busy) begin
        n_chk++;
        if (bus.ram_addr !== g_addr)
          $display("FAIL rnd_addr c%0d: got %h expected %h", c, bus.ram_addr, g_addr);
        else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
        if (exp_gnt[i]) begin
          dreq[i] = 1'b0;
        end else if (!dreq[i] && $urandom_range(0, 2) == 0) begin
          dreq[i]  = 1'b1;
          dwe[i]   = 1'($urandom_range(0, 1));
          daddr[i] = 8'($urandom_range(0, 7));
          dwd[i]   = 8'($urandom);
        end
      end
      bus.req_0 = dreq[0]; bus.we_0 = dwe[0]; bus.addr_0 = daddr[0]; bus.wdata_0 = dwd[0];
      bus.req_1 = dreq[1]; bus.we_1 = dwe[1]; bus.addr_1 = daddr[1]; bus.wdata_1 = dwd[1];
    end
    clear_inputs();
    repeat (3) tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] e;
    reset = 1'b0;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1; bus.lock_0 = 1'b1;
    bus.we_0 = 1'b0; bus.we_1 = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      e = 2'b00;
      if (c % 3 == 1) e = (((c - 1) / 3) == 4) ? 2'b10 : 2'b01;
      n_chk++;
      if ({bus.gnt_1, bus.gnt_0} !== e)
        $display("FAIL lock_gnt c%0d: got %b expected %b", c, {bus.gnt_1, bus.gnt_0}, e);
      else n_pass++;
    end
    clear_inputs();
    repeat (3) tick();
  endtask
`endif

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    clear_inputs();
    repeat (2) tick();
    test_reset();
    for (int i = 0; i < 256; i++) begin
      pre_we   = 1'b1;
      pre_addr = 8'(i);
      pre_data = (i == 16) ? 8'h5A : 8'($urandom);
      exp_mem[i] = pre_data;
      tick();
    end
    pre_we = 1'b0;
    reset = 1'b1;
    tick();
    test_read();
    test_write_readback();
    test_round_robin();
    test_reset_mid_write();
    test_idle();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
